// File: rtl/chal_responder_if.sv
// Byte-stream and ChaCha20 core signals of the challenge/response responder.
// master: the responder's view; slave: the UART/core side.
interface chal_responder_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_busy;
  logic         chacha_start;
  logic         chacha_ready;
  logic [95:0]  chacha_nonce;
  logic [127:0] chacha_output;
  logic         chacha_valid;
  logic         busy;
  logic         resp_done;
  logic         fmt_err;
  logic         rx_dropped;

  modport master (
    input  rx_data, rx_valid, tx_busy, chacha_ready, chacha_output, chacha_valid,
    output tx_data, tx_valid, chacha_start, chacha_nonce, busy, resp_done, fmt_err, rx_dropped
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, chacha_ready, chacha_output, chacha_valid,
    input  tx_data, tx_valid, chacha_start, chacha_nonce, busy, resp_done, fmt_err, rx_dropped
  );
endinterface

// File: rtl/chal_responder.sv
// Parses "CHAL:<24 hex>\n", runs the ChaCha20 core on the nonce and answers "RESP:<32 hex>\n".
// Define RESP_CRLF_EN to terminate the response with "\r\n" instead of "\n".
module chal_responder #(
  parameter int unsigned RX_TIMEOUT = 600_000,
  parameter bit          HEX_UPPER  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  chal_responder_if.master bus
);

`ifdef RESP_CRLF_EN
  localparam logic [5:0] LastIdx = 6'd39;
`else
  localparam logic [5:0] LastIdx = 6'd38;
`endif

  localparam int unsigned TimerW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;

  localparam logic [7:0] ChC  = 8'h43;
  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;

  typedef enum logic [2:0] {
    StHunt, StHdr, StHex, StEol, StStart, StWait, StSend, StTxWait
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         hdr_idx_q, hdr_idx_d;
  logic [4:0]         hex_idx_q, hex_idx_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [127:0]       result_q, result_d;
  logic [5:0]         tx_idx_q, tx_idx_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               tx_busy_prev_q;

  logic               timeout_hit;
  logic               in_line;
  logic [4:0]         hex_dec;
  logic [5:0]         nib_diff;
  logic [4:0]         nib_sel;
  logic [7:0]         tx_byte;
  logic [5:0]         tx_idx_inc;

  logic               chacha_start;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               resp_done;
  logic               fmt_err;
  logic               busy;

  // {valid, value} of an ASCII hex digit, either case.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      return {1'b1, 4'(c[3:0] + 4'd9)};
    end
    return 5'b0;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] base;
    if (nib < 4'd10) base = 8'h30;
    else             base = HEX_UPPER ? 8'h37 : 8'h57;
    return base + {4'h0, nib};
  endfunction

  // Expected header character at hdr_idx; index 0 is the 'C' consumed in HUNT.
  function automatic logic [7:0] hdr_char(input logic [2:0] idx);
    case (idx)
      3'd1:    return 8'h48;
      3'd2:    return 8'h41;
      3'd3:    return 8'h4C;
      3'd4:    return 8'h3A;
      default: return ChC;
    endcase
  endfunction

  assign timeout_hit = (RX_TIMEOUT != 0) && (timer_q == TimerW'(RX_TIMEOUT));
  assign in_line     = (state_q == StHdr) || (state_q == StHex) || (state_q == StEol);
  assign hex_dec     = hex_decode(bus.rx_data);
  assign tx_idx_inc  = tx_idx_q + 6'd1;

  // Response bytes 5..36 walk the result from the most significant nibble down.
  assign nib_diff = 6'd36 - tx_idx_q;
  assign nib_sel  = nib_diff[4:0];

  always_comb begin
    tx_byte = ChLf;
    case (tx_idx_q)
      6'd0:    tx_byte = 8'h52;
      6'd1:    tx_byte = 8'h45;
      6'd2:    tx_byte = 8'h53;
      6'd3:    tx_byte = 8'h50;
      6'd4:    tx_byte = 8'h3A;
      default: begin
        if (tx_idx_q <= 6'd36) begin
          tx_byte = hex_ascii(result_q[{nib_sel, 2'b00} +: 4]);
`ifdef RESP_CRLF_EN
        end else if (tx_idx_q == 6'd37) begin
          tx_byte = ChCr;
`endif
        end else begin
          tx_byte = ChLf;
        end
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    hex_idx_d    = hex_idx_q;
    nonce_d      = nonce_q;
    result_d     = result_q;
    tx_idx_d     = tx_idx_q;
    timer_d      = in_line ? timer_q + TimerW'(1) : '0;
    chacha_start = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    resp_done    = 1'b0;
    fmt_err      = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (bus.rx_valid && bus.rx_data == ChC) begin
          hdr_idx_d = 3'd1;
          timer_d   = '0;
          state_d   = StHdr;
        end
      end

      StHdr: begin
        if (bus.rx_valid) begin
          timer_d = '0;
          if (bus.rx_data == hdr_char(hdr_idx_q)) begin
            if (hdr_idx_q == 3'd4) begin
              hdr_idx_d = 3'd0;
              hex_idx_d = 5'd0;
              state_d   = StHex;
            end else begin
              hdr_idx_d = hdr_idx_q + 3'd1;
            end
          end else begin
            fmt_err = 1'b1;
            // A stray 'C' is treated as the start of a fresh header.
            if (bus.rx_data == ChC) begin
              hdr_idx_d = 3'd1;
            end else begin
              hdr_idx_d = 3'd0;
              state_d   = StHunt;
            end
          end
        end else if (timeout_hit) begin
          fmt_err   = 1'b1;
          hdr_idx_d = 3'd0;
          state_d   = StHunt;
        end
      end

      StHex: begin
        if (bus.rx_valid) begin
          timer_d = '0;
          if (hex_dec[4]) begin
            nonce_d = {nonce_q[91:0], hex_dec[3:0]};
            if (hex_idx_q == 5'd23) begin
              hex_idx_d = 5'd0;
              state_d   = StEol;
            end else begin
              hex_idx_d = hex_idx_q + 5'd1;
            end
          end else begin
            fmt_err   = 1'b1;
            hex_idx_d = 5'd0;
            state_d   = StHunt;
          end
        end else if (timeout_hit) begin
          fmt_err   = 1'b1;
          hex_idx_d = 5'd0;
          state_d   = StHunt;
        end
      end

      StEol: begin
        if (bus.rx_valid) begin
          timer_d = '0;
          if (bus.rx_data == ChLf) begin
            state_d = StStart;
          end else if (bus.rx_data != ChCr) begin
            fmt_err = 1'b1;
            state_d = StHunt;
          end
        end else if (timeout_hit) begin
          fmt_err = 1'b1;
          state_d = StHunt;
        end
      end

      StStart: begin
        if (bus.chacha_ready) begin
          chacha_start = 1'b1;
          state_d      = StWait;
        end
      end

      StWait: begin
        if (bus.chacha_valid) begin
          result_d = bus.chacha_output;
          tx_idx_d = 6'd0;
          state_d  = StSend;
        end
      end

      StSend: begin
        if (!bus.tx_busy) begin
          tx_valid = 1'b1;
          tx_data  = tx_byte;
          state_d  = StTxWait;
        end
      end

      StTxWait: begin
        // A byte has left the UART once its busy flag falls.
        if (tx_busy_prev_q && !bus.tx_busy) begin
          if (tx_idx_inc == LastIdx) begin
            resp_done = 1'b1;
            tx_idx_d  = 6'd0;
            state_d   = StHunt;
          end else begin
            tx_idx_d = tx_idx_inc;
            state_d  = StSend;
          end
        end
      end

      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StHunt;
      hdr_idx_q      <= 3'd0;
      hex_idx_q      <= 5'd0;
      nonce_q        <= 96'd0;
      result_q       <= 128'd0;
      tx_idx_q       <= 6'd0;
      timer_q        <= '0;
      tx_busy_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_idx_q      <= hdr_idx_d;
      hex_idx_q      <= hex_idx_d;
      nonce_q        <= nonce_d;
      result_q       <= result_d;
      tx_idx_q       <= tx_idx_d;
      timer_q        <= timer_d;
      tx_busy_prev_q <= bus.tx_busy;
    end
  end

  assign busy = !(state_q == StHunt || in_line);

  assign bus.chacha_start = chacha_start;
  assign bus.chacha_nonce = nonce_q;
  assign bus.tx_valid     = tx_valid;
  assign bus.tx_data      = tx_data;
  assign bus.resp_done    = resp_done;
  assign bus.fmt_err      = fmt_err;
  assign bus.busy         = busy;
  assign bus.rx_dropped   = busy && bus.rx_valid;

endmodule

// File: tb/tb_chal_responder.sv
// Self-checking bench for chal_responder: models the ChaCha20 core and uart_tx, drives random lines.
module tb_chal_responder;
  localparam int unsigned TbTimeout = 200;
`ifdef RESP_CRLF_EN
  localparam int RespLen = 39;
`else
  localparam int RespLen = 38;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chal_responder_if bus ();

  chal_responder #(
    .RX_TIMEOUT(TbTimeout),
    .HEX_UPPER (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Core and UART behavioural models.
  logic [127:0] core_result;
  int           core_lat = 3;
  int           core_cnt;
  int           tx_lat = 3;
  int           tx_cnt;
  logic [7:0]   tx_q[$];

  always @(posedge clk) begin
    if (rst) begin
      bus.chacha_ready  <= 1'b1;
      bus.chacha_valid  <= 1'b0;
      bus.chacha_output <= '0;
      core_cnt          <= 0;
    end else begin
      bus.chacha_valid <= 1'b0;
      if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          bus.chacha_valid  <= 1'b1;
          bus.chacha_output <= core_result;
          bus.chacha_ready  <= 1'b1;
        end
      end else if (bus.chacha_start) begin
        bus.chacha_ready <= 1'b0;
        core_cnt         <= core_lat;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      bus.tx_busy <= 1'b0;
      tx_cnt      <= 0;
    end else if (bus.tx_valid) begin
      tx_q.push_back(bus.tx_data);
      bus.tx_busy <= 1'b1;
      tx_cnt      <= tx_lat;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) bus.tx_busy <= 1'b0;
    end
  end

  // Event monitor, sampled away from the active edge.
  int          n_start = 0, n_fmt = 0, n_drop = 0, n_done = 0, nonce_err = 0, tx_overlap = 0;
  logic [95:0] start_nonce = '0;
  int          done_bytes = 0;
  logic        done_busy = 1'b0;
  bit          core_running = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.chacha_start) begin
        n_start++;
        start_nonce = bus.chacha_nonce;
      end
      if (bus.chacha_start) core_running = 1'b1;
      else if (bus.chacha_valid) core_running = 1'b0;
      else if (core_running && bus.chacha_nonce !== start_nonce) nonce_err++;
      if (bus.fmt_err) n_fmt++;
      if (bus.rx_dropped) n_drop++;
      if (bus.tx_valid && bus.tx_busy) tx_overlap++;
      if (bus.resp_done) begin
        n_done++;
        done_bytes = tx_q.size();
        done_busy  = bus.tx_busy;
      end
    end else begin
      core_running = 1'b0;
    end
  end

  function automatic logic [7:0] hex_char(input logic [3:0] nib, input bit lower);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return (lower ? 8'h61 : 8'h41) + {4'h0, nib} - 8'd10;
  endfunction

  // Reference response: "RESP:", 32 upper-case hex digits MS first, line terminator.
  function automatic logic [7:0] exp_byte(input logic [127:0] r, input int i);
    logic [39:0] hdr;
    hdr = 40'h524553503A;
    if (i < 5) return hdr[8*(4-i) +: 8];
    if (i < 37) return hex_char(4'((r >> (4 * (31 - (i - 5)))) & 128'hF), 1'b0);
`ifdef RESP_CRLF_EN
    if (i == 37) return 8'h0D;
`endif
    return 8'h0A;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // mode 0: upper-case digits, 1: lower-case, 2: random per digit.
  task automatic send_line(input logic [95:0] nonce, input int mode, input bit crlf,
                           input int maxgap);
    logic [39:0] hdr;
    logic [3:0]  nib;
    bit          lower;
    hdr = 40'h4348414C3A;
    for (int i = 0; i < 5; i++) send_byte(hdr[8*(4-i) +: 8], int'($urandom_range(0, maxgap)));
    for (int i = 0; i < 24; i++) begin
      nib   = 4'((nonce >> (4 * (23 - i))) & 96'hF);
      lower = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
      send_byte(hex_char(nib, lower), int'($urandom_range(0, maxgap)));
    end
    if (crlf) send_byte(8'h0D, 0);
    send_byte(8'h0A, 0);
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (n_done < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n_done < target) begin
      errors++;
      $display("FAIL %s resp_done wait: got %0d pulses, required %0d", name, n_done, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", bus.busy); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset tx_valid: got %b required 0", bus.tx_valid); end
    checks++; if (bus.chacha_start !== 1'b0) begin errors++; $display("FAIL reset chacha_start: got %b required 0", bus.chacha_start); end
    checks++; if (bus.chacha_nonce !== 96'd0) begin errors++; $display("FAIL reset nonce: got %h required 0", bus.chacha_nonce); end
    checks++; if ({bus.fmt_err, bus.resp_done, bus.rx_dropped} !== 3'b000) begin
      errors++; $display("FAIL reset pulses: got %b required 000", {bus.fmt_err, bus.resp_done, bus.rx_dropped});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int s0, f0, d0, base;
    logic [7:0] got;
    core_result = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    s0 = n_start; f0 = n_fmt; d0 = n_done; base = tx_q.size();
    send_line(96'h0123456789ABCDEF00112233, 0, 1'b0, 0);
    wait_done(d0 + 1, "basic");
    repeat (20) @(negedge clk);
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL basic start count: got %0d required 1", n_start - s0); end
    checks++; if (start_nonce !== 96'h0123456789ABCDEF00112233) begin
      errors++; $display("FAIL basic nonce: got %h required 0123456789abcdef00112233", start_nonce);
    end
    checks++; if (n_fmt - f0 !== 0) begin errors++; $display("FAIL basic fmt_err: got %0d required 0", n_fmt - f0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL basic done count: got %0d required 1", n_done - d0); end
    checks++; if (done_bytes - base !== RespLen || done_busy !== 1'b0) begin
      errors++; $display("FAIL basic done timing: got %0d bytes busy %b required %0d bytes busy 0",
                         done_bytes - base, done_busy, RespLen);
    end
    checks++; if (tx_q.size() - base !== RespLen) begin
      errors++; $display("FAIL basic length: got %0d required %0d", tx_q.size() - base, RespLen);
    end
    for (int i = 0; i < RespLen; i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
      checks++;
      if (got !== exp_byte(core_result, i)) begin
        errors++; $display("FAIL basic byte %0d: got %h required %h", i, got, exp_byte(core_result, i));
      end
    end
  endtask

  task automatic test_bad_hex();
    int s0, f0, d0, base;
    logic [95:0] nonce;
    logic [7:0]  bad[9];
    logic [7:0]  got;
    bad = '{8'h43, 8'h48, 8'h41, 8'h4C, 8'h3A, 8'h30, 8'h31, 8'h47, 8'h33};
    s0 = n_start; f0 = n_fmt;
    for (int i = 0; i < 9; i++) begin
      send_byte(bad[i], 0);
      if (i == 7) begin
        checks++; if (n_fmt - f0 !== 1) begin errors++; $display("FAIL badhex fmt at G: got %0d required 1", n_fmt - f0); end
      end
    end
    repeat (30) @(negedge clk);
    checks++; if (n_start - s0 !== 0) begin errors++; $display("FAIL badhex start: got %0d required 0", n_start - s0); end
    checks++; if (n_fmt - f0 !== 1) begin errors++; $display("FAIL badhex fmt total: got %0d required 1", n_fmt - f0); end
    nonce = {$urandom, $urandom, $urandom};
    core_result = {$urandom, $urandom, $urandom, $urandom};
    d0 = n_done; base = tx_q.size();
    send_line(nonce, 2, 1'b0, 2);
    wait_done(d0 + 1, "badhex recovery");
    checks++; if (start_nonce !== nonce) begin errors++; $display("FAIL badhex recovery nonce: got %h required %h", start_nonce, nonce); end
    for (int i = 0; i < RespLen; i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
      checks++;
      if (got !== exp_byte(core_result, i)) begin
        errors++; $display("FAIL badhex recovery byte %0d: got %h required %h", i, got, exp_byte(core_result, i));
      end
    end
  endtask

  task automatic test_resync();
    int s0, f0, d0, base;
    logic [95:0] nonce;
    logic [7:0]  got;
    nonce = {$urandom, $urandom, $urandom};
    core_result = {$urandom, $urandom, $urandom, $urandom};
    s0 = n_start; f0 = n_fmt; d0 = n_done; base = tx_q.size();
    send_byte(8'h43, 0);
    send_byte(8'h48, 0);
    send_line(nonce, 0, 1'b1, 1);
    wait_done(d0 + 1, "resync");
    checks++; if (n_fmt - f0 !== 1) begin errors++; $display("FAIL resync fmt: got %0d required 1", n_fmt - f0); end
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL resync start: got %0d required 1", n_start - s0); end
    checks++; if (start_nonce !== nonce) begin errors++; $display("FAIL resync nonce: got %h required %h", start_nonce, nonce); end
    for (int i = 0; i < RespLen; i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
      checks++;
      if (got !== exp_byte(core_result, i)) begin
        errors++; $display("FAIL resync byte %0d: got %h required %h", i, got, exp_byte(core_result, i));
      end
    end
  endtask

  task automatic test_drop_and_reset();
    int dr0, f0, d0, base, n;
    logic [7:0] got;
    core_result = {$urandom, $urandom, $urandom, $urandom};
    dr0 = n_drop; f0 = n_fmt; d0 = n_done; base = tx_q.size();
    send_line({$urandom, $urandom, $urandom}, 2, 1'b0, 0);
    n = 0;
    while (tx_q.size() - base < 3 && n < 2000) begin @(negedge clk); n++; end
    send_byte(8'h43, 0);
    wait_done(d0 + 1, "drop");
    checks++; if (n_drop - dr0 !== 1) begin errors++; $display("FAIL drop count: got %0d required 1", n_drop - dr0); end
    checks++; if (n_fmt - f0 !== 0) begin errors++; $display("FAIL drop fmt: got %0d required 0", n_fmt - f0); end
    for (int i = 0; i < RespLen; i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
      checks++;
      if (got !== exp_byte(core_result, i)) begin
        errors++; $display("FAIL drop byte %0d: got %h required %h", i, got, exp_byte(core_result, i));
      end
    end
    // Abort mid-transmit.
    d0 = n_done; base = tx_q.size();
    send_line({$urandom, $urandom, $urandom}, 0, 1'b0, 0);
    n = 0;
    while (tx_q.size() - base < 10 && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL abort tx_valid: got %b required 0", bus.tx_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b required 0", bus.busy); end
    checks++; if (bus.chacha_nonce !== 96'd0) begin errors++; $display("FAIL abort nonce: got %h required 0", bus.chacha_nonce); end
    repeat (100) @(negedge clk);
    checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL abort resp_done: got %0d required 0", n_done - d0); end
    checks++; if (tx_q.size() - base !== 10) begin errors++; $display("FAIL abort bytes: got %0d required 10", tx_q.size() - base); end
  endtask

  task automatic test_timeout();
    int s0, f0, d0, base, n;
    logic [95:0] nonce;
    logic [7:0]  got;
    s0 = n_start; f0 = n_fmt;
    send_byte(8'h43, 0); send_byte(8'h48, 0); send_byte(8'h41, 0); send_byte(8'h4C, 0);
    send_byte(8'h3A, 0); send_byte(8'h31, 0); send_byte(8'h32, 0);
    n = 0;
    while (n_fmt == f0 && n < int'(TbTimeout) + 20) begin @(negedge clk); n++; end
    checks++; if (n_fmt - f0 !== 1) begin errors++; $display("FAIL timeout fmt: got %0d required 1", n_fmt - f0); end
    checks++; if (n < int'(TbTimeout) - 2 || n > int'(TbTimeout) + 3) begin
      errors++; $display("FAIL timeout latency: got %0d cycles required about %0d", n, TbTimeout);
    end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || n_start - s0 !== 0) begin
      errors++; $display("FAIL timeout state: got busy %b starts %0d required 0 0", bus.busy, n_start - s0);
    end
    nonce = 96'habcdef0123456789abcdef01;
    core_result = {$urandom, $urandom, $urandom, $urandom};
    d0 = n_done; base = tx_q.size();
    send_line(nonce, 1, 1'b0, 1);
    wait_done(d0 + 1, "lowercase");
    checks++; if (start_nonce !== nonce) begin errors++; $display("FAIL lowercase nonce: got %h required %h", start_nonce, nonce); end
    for (int i = 0; i < RespLen; i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
      checks++;
      if (got !== exp_byte(core_result, i)) begin
        errors++; $display("FAIL lowercase byte %0d: got %h required %h", i, got, exp_byte(core_result, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int s0, d0, base;
    logic [95:0] nonce;
    logic [7:0]  got;
    for (int k = 0; k < 6; k++) begin
      nonce       = {$urandom, $urandom, $urandom};
      core_result = {$urandom, $urandom, $urandom, $urandom};
      core_lat    = int'($urandom_range(1, 8));
      tx_lat      = int'($urandom_range(1, 6));
      s0 = n_start; d0 = n_done; base = tx_q.size();
      send_line(nonce, 2, $urandom_range(0, 1) == 1, 3);
      wait_done(d0 + 1, "b2b");
      checks++; if (n_start - s0 !== 1 || start_nonce !== nonce) begin
        errors++; $display("FAIL b2b line %0d nonce: got %h (%0d starts) required %h", k, start_nonce,
                           n_start - s0, nonce);
      end
      for (int i = 0; i < RespLen; i++) begin
        got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
        checks++;
        if (got !== exp_byte(core_result, i)) begin
          errors++; $display("FAIL b2b line %0d byte %0d: got %h required %h", k, i, got,
                             exp_byte(core_result, i));
        end
      end
    end
    checks++; if (nonce_err !== 0) begin errors++; $display("FAIL nonce stability: got %0d changes required 0", nonce_err); end
    checks++; if (tx_overlap !== 0) begin errors++; $display("FAIL tx overlap: got %0d required 0", tx_overlap); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_hex();
    test_resync();
    test_drop_and_reset();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
